// File: rtl/maze_route_fork.sv
// maze_route_fork: computes the [N,W,S,E,B] request set of one packet and forks it to every requested output.
// Latency: out_valid appears one cycle after accept; drop_err pulses one cycle after a discarded accept.
// Backpressure: single-entry slot; in_ready only when every still-pending copy is accepted this cycle.
module maze_route_fork #(
  parameter int COORD_W = 3,
  parameter int MESH_X  = 8,
  parameter int MESH_Y  = 8,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_tgt_x,
  input  logic [COORD_W-1:0] in_tgt_y,
  input  logic [COORD_W-1:0] in_src_x,
  input  logic [COORD_W-1:0] in_src_y,
  input  logic [1:0]         in_pkt_type,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               pg_en,
  input  logic [COORD_W-1:0] pg_node_x,
  input  logic [COORD_W-1:0] pg_node_y,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [COORD_W-1:0] out_tgt_x,
  output logic [COORD_W-1:0] out_tgt_y,
  output logic [COORD_W-1:0] out_src_x,
  output logic [COORD_W-1:0] out_src_y,
  output logic [1:0]         out_pkt_type,
  output logic [DATA_W-1:0]  out_data,
  output logic               drop_err
);

  // Output index of each direction inside the request vector.
  localparam int DIR_N = 0;
  localparam int DIR_W = 1;
  localparam int DIR_S = 2;
  localparam int DIR_E = 3;
  localparam int DIR_B = 4;

  localparam bit TOP = (LOCAL_Y == MESH_Y - 1);
  localparam bit BOT = (LOCAL_Y == 0);
  localparam bit RGT = (LOCAL_X == MESH_X - 1);
  localparam bit LFT = (LOCAL_X == 0);

  // Directions that lead to a real neighbour; B (local eject) always exists.
  localparam logic [4:0] EXISTS = {1'b1, !RGT, !BOT, !LFT, !TOP};

  // Coordinates are compared one bit wider so that LOCAL-1 at the left/bottom edge
  // wraps to a value no zero-extended fault coordinate can match, and LOCAL+1 never overflows.
  localparam int LXP_I = LOCAL_X + 1;
  localparam int LXM_I = LOCAL_X - 1;
  localparam int LYP_I = LOCAL_Y + 1;
  localparam int LYM_I = LOCAL_Y - 1;
  localparam logic [COORD_W:0] LX   = LOCAL_X[COORD_W:0];
  localparam logic [COORD_W:0] LY   = LOCAL_Y[COORD_W:0];
  localparam logic [COORD_W:0] LX_P = LXP_I[COORD_W:0];
  localparam logic [COORD_W:0] LX_M = LXM_I[COORD_W:0];
  localparam logic [COORD_W:0] LY_P = LYP_I[COORD_W:0];
  localparam logic [COORD_W:0] LY_M = LYM_I[COORD_W:0];

  typedef struct packed {
    logic [1:0]         pkt_type;
    logic [COORD_W-1:0] tgt_x;
    logic [COORD_W-1:0] tgt_y;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] src_y;
  } hdr_t;

  logic [COORD_W:0]  tx, ty, sx, sy, fx, fy;
  logic [4:0]        xy;
  logic [4:0]        uni;
  logic [4:0]        route_raw;
  logic [4:0]        route;
  logic              hop_fault;
  logic              tgt_fault;
  logic              accept;
  logic [4:0]        pending;
  hdr_t              hdr_q;
  logic [DATA_W-1:0] data_q;

  assign tx = {1'b0, in_tgt_x};
  assign ty = {1'b0, in_tgt_y};
  assign sx = {1'b0, in_src_x};
  assign sy = {1'b0, in_src_y};
  assign fx = {1'b0, pg_node_x};
  assign fy = {1'b0, pg_node_y};

  // Dimension-ordered next hop: resolve x first, then y, eject when both match.
  always_comb begin
    xy = '0;
    if (tx > LX)      xy[DIR_E] = 1'b1;
    else if (tx < LX) xy[DIR_W] = 1'b1;
    else if (ty > LY) xy[DIR_N] = 1'b1;
    else if (ty < LY) xy[DIR_S] = 1'b1;
    else              xy[DIR_B] = 1'b1;
  end

  assign hop_fault = (xy[DIR_E] && fx == LX_P && fy == LY)
                  || (xy[DIR_W] && fx == LX_M && fy == LY)
                  || (xy[DIR_N] && fx == LX   && fy == LY_P)
                  || (xy[DIR_S] && fx == LX   && fy == LY_M);
  assign tgt_fault = (tx == fx) && (ty == fy);

  // Unicast: XY hop, swapped for a perpendicular detour when that hop lands on the faulty node.
  always_comb begin
    uni = xy;
    if (pg_en && hop_fault) begin
      uni = '0;
      if (xy[DIR_E] || xy[DIR_W]) begin
        if (ty > LY)      uni[DIR_N] = 1'b1;
        else if (ty < LY) uni[DIR_S] = 1'b1;
        else if (TOP)     uni[DIR_S] = 1'b1;
        else              uni[DIR_N] = 1'b1;
      end else if (RGT) begin
        uni[DIR_W] = 1'b1;
      end else begin
        uni[DIR_E] = 1'b1;
      end
    end
    if (pg_en && tgt_fault) uni = '0;
  end

  // Request set per packet type; anything but unicast is refused while a fault is flagged.
  always_comb begin
    route_raw = '0;
    case (in_pkt_type)
      2'b00: route_raw = uni;
      2'b01: begin
        if (tx > LX)      route_raw[DIR_E] = 1'b1;
        else if (tx < LX) route_raw[DIR_W] = 1'b1;
        else begin
          route_raw[DIR_B] = 1'b1;
          route_raw[DIR_N] = (LY >= sy) && !TOP;
          route_raw[DIR_S] = (LY <= sy) && !BOT;
        end
      end
      2'b10: begin
        if (ty > LY)      route_raw[DIR_N] = 1'b1;
        else if (ty < LY) route_raw[DIR_S] = 1'b1;
        else begin
          route_raw[DIR_B] = 1'b1;
          route_raw[DIR_E] = (LX >= sx) && !RGT;
          route_raw[DIR_W] = (LX <= sx) && !LFT;
        end
      end
      2'b11: begin
        route_raw[DIR_B] = 1'b1;
        route_raw[DIR_N] = (LY >= sy) && !TOP;
        route_raw[DIR_S] = (LY <= sy) && !BOT;
        route_raw[DIR_E] = (LY == sy) && (LX >= sx) && !RGT;
        route_raw[DIR_W] = (LY == sy) && (LX <= sx) && !LFT;
      end
    endcase
    if (pg_en && in_pkt_type != 2'b00) route_raw = '0;
  end

  // A hop toward a missing neighbour (malformed target) is masked out and so becomes a drop.
  assign route    = route_raw & EXISTS;
  assign in_ready = (pending & ~out_ready) == 5'b00000;
  assign accept   = in_valid && in_ready;

  // Slot: capture on accept, otherwise retire each copy as its output takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      hdr_q    <= '0;
      data_q   <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= accept && (route == 5'b00000);
      if (accept) begin
        pending        <= route;
        hdr_q.pkt_type <= in_pkt_type;
        hdr_q.tgt_x    <= in_tgt_x;
        hdr_q.tgt_y    <= in_tgt_y;
        hdr_q.src_x    <= in_src_x;
        hdr_q.src_y    <= in_src_y;
        data_q         <= in_data;
      end else begin
        pending <= pending & ~out_ready;
      end
    end
  end

  assign out_valid    = pending;
  assign out_tgt_x    = hdr_q.tgt_x;
  assign out_tgt_y    = hdr_q.tgt_y;
  assign out_src_x    = hdr_q.src_x;
  assign out_src_y    = hdr_q.src_y;
  assign out_pkt_type = hdr_q.pkt_type;
  assign out_data     = data_q;

endmodule
